// File: rtl/delay_meter_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : delay_meter_fsm
//  Description : Measures the number of clock cycles between a rising edge on
//                start_in and a rising edge on stop_in. Both pads are
//                synchronised before use. An IDLE/ARMED/MEASURE/DONE machine
//                runs a cycle counter, latches the result, and aborts with
//                timeout_flag when no stop edge arrives within TIMEOUT cycles.
//                The 16-bit result is read out one byte at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_meter_fsm #(
  parameter int WIDTH       = 16,
  parameter int TIMEOUT     = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start_in,
  input  logic       stop_in,
  input  logic       arm,
  input  logic       byte_sel,
  output logic [7:0] result_out,
  output logic       busy,
  output logic       done,
  output logic       timeout_flag
);

  // Counter value at which a measurement gives up waiting for stop.
  localparam logic [WIDTH-1:0] c_timeout  = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] c_count_one = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Synchroniser chains and edge-detect history
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_start_sync;
  logic [SYNC_STAGES-1:0] r_stop_sync;
  logic                   r_start_prev;
  logic                   r_stop_prev;
  logic                   w_start_lvl;
  logic                   w_stop_lvl;
  logic                   w_start_e;
  logic                   w_stop_e;

  // --------------------------------------------------------------------------
  // FSM, counter and result storage
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_count_inc;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic             r_busy;
  logic             r_done;

  // Pad synchronisers run every cycle, independent of ena, so both paths
  // always see identical latency from pin to detected edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start_sync <= '0;
      r_stop_sync  <= '0;
      r_start_prev <= 1'b0;
      r_stop_prev  <= 1'b0;
    end else begin
      r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], start_in};
      r_stop_sync  <= {r_stop_sync[SYNC_STAGES-2:0], stop_in};
      r_start_prev <= w_start_lvl;
      r_stop_prev  <= w_stop_lvl;
    end
  end

  assign w_start_lvl = r_start_sync[SYNC_STAGES-1];
  assign w_stop_lvl  = r_stop_sync[SYNC_STAGES-1];

  // Single-cycle rising-edge strobes of the synchronised levels.
  assign w_start_e = w_start_lvl & ~r_start_prev;
  assign w_stop_e  = w_stop_lvl & ~r_stop_prev;

  // Counter value the measurement would hold after the current cycle; the
  // count is capped at TIMEOUT so this can never wrap.
  assign w_count_inc = r_count + c_count_one;

  // State register plus counter/result/flag storage and registered decodes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_result  <= w_result_nxt;
      r_timeout <= w_timeout_nxt;
      r_busy    <= (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_MEASURE);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state and datapath update. Everything holds while ena is low; arm
  // overrides any edge in the same cycle and always lands in ARMED with a
  // cleared counter. The result is only ever rewritten by a completed or
  // timed-out measurement.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_result_nxt  = r_result;
    w_timeout_nxt = r_timeout;

    if (ena) begin
      if (arm) begin
        w_state_nxt   = ST_ARMED;
        w_count_nxt   = '0;
        w_timeout_nxt = 1'b0;
      end else begin
        case (r_state)
          ST_ARMED: begin
            // A stop edge here (alone or together with start) is ignored.
            if (w_start_e) begin
              w_state_nxt = ST_MEASURE;
              w_count_nxt = '0;
            end
          end
          ST_MEASURE: begin
            // The start-edge cycle leaves count at 0, so a stop N cycles
            // later sees count = N-1 and latches count+1 = N.
            if (w_stop_e) begin
              w_result_nxt = w_count_inc;
              w_state_nxt  = ST_DONE;
            end else if (w_count_inc == c_timeout) begin
              w_result_nxt  = c_timeout;
              w_count_nxt   = w_count_inc;
              w_timeout_nxt = 1'b1;
              w_state_nxt   = ST_DONE;
            end else begin
              w_count_nxt = w_count_inc;
            end
          end
          default: begin
            // IDLE and DONE wait for arm.
          end
        endcase
      end
    end
  end

  // Byte readout is a pure mux so byte_sel takes effect in the same cycle.
  assign result_out   = byte_sel ? r_result[15:8] : r_result[7:0];
  assign busy         = r_busy;
  assign done         = r_done;
  assign timeout_flag = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_delay_meter_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_meter_fsm
//  Description : Directed self-checking bench for delay_meter_fsm. A default
//                instance covers normal measurements; a second instance with
//                TIMEOUT=100 shares the same stimulus for the timeout case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_meter_fsm;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start_in;
  logic       stop_in;
  logic       arm;
  logic       byte_sel;

  logic [7:0] result_out;
  logic       busy;
  logic       done;
  logic       timeout_flag;

  logic [7:0] to_result_out;
  logic       to_busy;
  logic       to_done;
  logic       to_timeout_flag;

  int n_total;
  int n_pass;
  int n_fail;

  delay_meter_fsm #(
    .WIDTH       (16),
    .TIMEOUT     (50000),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .start_in     (start_in),
    .stop_in      (stop_in),
    .arm          (arm),
    .byte_sel     (byte_sel),
    .result_out   (result_out),
    .busy         (busy),
    .done         (done),
    .timeout_flag (timeout_flag)
  );

  delay_meter_fsm #(
    .WIDTH       (16),
    .TIMEOUT     (100),
    .SYNC_STAGES (2)
  ) dut_to (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .start_in     (start_in),
    .stop_in      (stop_in),
    .arm          (arm),
    .byte_sel     (byte_sel),
    .result_out   (to_result_out),
    .busy         (to_busy),
    .done         (to_done),
    .timeout_flag (to_timeout_flag)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check both result bytes of the default instance; byte_sel is combinational.
  task automatic chk_bytes(input string tag, input logic [7:0] lo, input logic [7:0] hi);
    byte_sel = 1'b0;
    #1;
    chk({tag, "_lo"}, {8'h00, result_out}, {8'h00, lo});
    byte_sel = 1'b1;
    #1;
    chk({tag, "_hi"}, {8'h00, result_out}, {8'h00, hi});
    byte_sel = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic pins_low();
    start_in = 1'b0;
    stop_in  = 1'b0;
    tick(4);
  endtask

  initial begin
    n_total  = 0;
    n_pass   = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    ena      = 1'b1;
    start_in = 1'b0;
    stop_in  = 1'b0;
    arm      = 1'b0;
    byte_sel = 1'b0;

    // Reset with noisy inputs.
    tick(1);
    arm = 1'b1; start_in = 1'b1; stop_in = 1'b0;
    tick(1);
    arm = 1'b0; start_in = 1'b0; stop_in = 1'b1;
    tick(1);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_tflag", {15'd0, timeout_flag}, 16'd0);
    chk_bytes("rst_result", 8'h00, 8'h00);
    rst_n   = 1'b1;
    stop_in = 1'b0;
    tick(4);
    chk("idle_busy", {15'd0, busy}, 16'd0);

    // Basic 37-cycle measurement.
    pulse_arm();
    chk("armed_busy", {15'd0, busy}, 16'd1);
    start_in = 1'b1;
    tick(37);
    stop_in = 1'b1;
    tick(2);
    chk("m37_not_done_yet", {15'd0, done}, 16'd0);
    tick(1);
    chk("m37_done", {15'd0, done}, 16'd1);
    chk("m37_busy", {15'd0, busy}, 16'd0);
    chk("m37_tflag", {15'd0, timeout_flag}, 16'd0);
    chk_bytes("m37", 8'h25, 8'h00);
    pins_low();

    // Wide 1000-cycle measurement; arm in DONE clears done next cycle.
    pulse_arm();
    chk("rearm_done_clr", {15'd0, done}, 16'd0);
    start_in = 1'b1;
    tick(1000);
    stop_in = 1'b1;
    tick(3);
    chk("m1000_done", {15'd0, done}, 16'd1);
    chk("m1000_tflag", {15'd0, timeout_flag}, 16'd0);
    chk_bytes("m1000", 8'hE8, 8'h03);
    pins_low();

    // Timeout on the TIMEOUT=100 instance.
    pulse_arm();
    start_in = 1'b1;
    tick(102);
    chk("to_not_done_yet", {15'd0, to_done}, 16'd0);
    tick(1);
    chk("to_done", {15'd0, to_done}, 16'd1);
    chk("to_tflag", {15'd0, to_timeout_flag}, 16'd1);
    chk("to_busy", {15'd0, to_busy}, 16'd0);
    chk("to_result_lo", {8'h00, to_result_out}, 16'h0064);
    chk("dflt_still_busy", {15'd0, busy}, 16'd1);
    pins_low();

    // Stop before start in ARMED is ignored.
    pulse_arm();
    chk("to_rearm_tflag_clr", {15'd0, to_timeout_flag}, 16'd0);
    stop_in = 1'b1;
    tick(5);
    chk("early_stop_busy", {15'd0, busy}, 16'd1);
    chk("early_stop_done", {15'd0, done}, 16'd0);
    stop_in = 1'b0;
    tick(4);
    start_in = 1'b1;
    tick(8);
    stop_in = 1'b1;
    tick(3);
    chk("m8_done", {15'd0, done}, 16'd1);
    chk_bytes("m8", 8'h08, 8'h00);
    pins_low();

    // Coincident start/stop: stop ignored, a later stop 5 cycles on counts.
    pulse_arm();
    start_in = 1'b1;
    stop_in  = 1'b1;
    tick(2);
    stop_in = 1'b0;
    tick(3);
    stop_in = 1'b1;
    tick(2);
    chk("coinc_still_busy", {15'd0, busy}, 16'd1);
    tick(1);
    chk("coinc_done", {15'd0, done}, 16'd1);
    chk_bytes("coinc", 8'h05, 8'h00);
    pins_low();

    // ena low for 10 cycles mid-measurement; 20 enabled cycles start-to-stop.
    pulse_arm();
    start_in = 1'b1;
    tick(8);
    ena = 1'b0;
    tick(10);
    ena = 1'b1;
    tick(12);
    stop_in = 1'b1;
    tick(3);
    chk("ena_done", {15'd0, done}, 16'd1);
    chk_bytes("ena", 8'h14, 8'h00);
    pins_low();

    // Abort during MEASURE keeps busy and the old result, then 12-cycle run.
    pulse_arm();
    start_in = 1'b1;
    tick(10);
    pulse_arm();
    chk("abort_busy", {15'd0, busy}, 16'd1);
    chk("abort_done", {15'd0, done}, 16'd0);
    chk_bytes("abort_hold", 8'h14, 8'h00);
    start_in = 1'b0;
    tick(4);
    start_in = 1'b1;
    tick(12);
    stop_in = 1'b1;
    tick(2);
    chk("m12_not_done_yet", {15'd0, done}, 16'd0);
    tick(1);
    chk("m12_done", {15'd0, done}, 16'd1);
    chk_bytes("m12", 8'h0C, 8'h00);
    pulse_arm();
    chk("final_done_clr", {15'd0, done}, 16'd0);
    chk("final_busy", {15'd0, busy}, 16'd1);
    chk_bytes("final_hold", 8'h0C, 8'h00);

    // Reset mid-measurement clears the result.
    start_in = 1'b0;
    stop_in  = 1'b0;
    rst_n    = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("rst2_busy", {15'd0, busy}, 16'd0);
    chk_bytes("rst2_result", 8'h00, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/delay_meter_fsm.md
Name: delay_meter_fsm

Overview:
Measures the delay in clock cycles between a rising edge on start_in and a rising edge on stop_in. Both pins are synchronised before use. An arm/measure/done FSM drives an internal cycle counter and latches the result. The latched 16-bit result is presented byte-wise so the 8-bit counter/output stage downstream can load and display it, with a timeout guarding a missing stop edge.

Parameters:
WIDTH, 16, width of cycle counter and result register (must be 16; byte_sel picks one of two bytes)
TIMEOUT, 50000, cycle count at which a measurement aborts with timeout_flag set (1 <= TIMEOUT <= 2^WIDTH-1)
SYNC_STAGES, 2, flip-flop stages on start_in/stop_in synchronisers (>=2)

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  synchronous active-low reset
ena  input  1  design enable; low freezes FSM and counter
start_in  input  1  asynchronous start pulse/level from pad
stop_in  input  1  asynchronous stop pulse/level from pad
arm  input  1  synchronous, level; high for a cycle arms/re-arms a measurement
byte_sel  input  1  0 = result[7:0], 1 = result[15:8] on result_out
result_out  output  8  selected byte of latched result (combinational mux of registers)
busy  output  1  high in ARMED or MEASURE
done  output  1  high in DONE
timeout_flag  output  1  high when last measurement hit TIMEOUT

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, count=0, result=0, timeout_flag=0, synchroniser and edge-detect flops=0; busy=0, done=0, result_out=0.
- Synchronisers run every cycle regardless of ena. Edge detect: start_e = s_sync & ~s_prev (likewise stop_e), one cycle wide.
- States: IDLE, ARMED, MEASURE, DONE. With ena low: no state, count, result or flag changes. Edges occurring then are lost.
- IDLE: arm=1 -> ARMED, count<=0, timeout_flag<=0.
- ARMED: start_e -> MEASURE, count<=0. stop_e alone is ignored. If start_e and stop_e coincide, start wins and the stop is ignored.
- MEASURE, start_e seen at cycle T:
  - stop_e at cycle T+N -> result<=N (result<=count+1), go DONE.
  - No stop_e: count<=count+1.
  - If count+1 == TIMEOUT without stop: result<=TIMEOUT, timeout_flag<=1, go DONE.
  - start_e in MEASURE is ignored (no restart).
- DONE: result and flags hold. arm=1 -> ARMED, timeout_flag<=0, result retained until next latch.
- arm=1 in ARMED or MEASURE: abort and go to ARMED, count<=0; result unchanged.
- arm has priority over start_e/stop_e in the same cycle.
- Count never wraps; TIMEOUT caps it.
- busy/done are registered state decodes, valid the cycle after the transition edge.
- result_out changes in the same cycle as byte_sel (no latency). Result updates become visible the cycle after the latching edge.
- Pin-to-detection latency is SYNC_STAGES+1 cycles, identical for start and stop, so N equals the pin-level delay.
- Reset mid-measurement returns to IDLE and clears result.

Test Plan:
- Reset: rst_n=0 for 2 cycles with arm/start/stop toggling -> result_out=0, busy=0, done=0, timeout_flag=0.
- Basic measurement: arm, then start_in high; stop_in high 37 cycles later -> done=1, result=37 (byte_sel=0 gives 0x25, byte_sel=1 gives 0x00), timeout_flag=0.
- Wide result: start-to-stop 1000 cycles -> result_out 0xE8 (sel 0) and 0x03 (sel 1).
- Timeout: TIMEOUT=100, start with no stop -> exactly 100 cycles after start detection done=1, timeout_flag=1, result=100.
- Edge cases:
  - stop before start in ARMED is ignored.
  - start and stop on the same cycle is ignored for stop; a later stop 5 cycles on gives result=5.
  - ena low for 10 cycles mid-measure with stop 20 cycles after start (ena-high cycles) gives result=20.
- Abort/re-arm: arm pulsed during MEASURE -> busy stays 1, previous result held. The new 12-cycle measurement gives result=12; arm in DONE clears done next cycle.
